// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose:
//   Instruction fetch stage that sits directly in front of the control path.
//   It owns the fetch PC and issues word reads to instruction memory over a
//   read/waitrequest handshake. Returned words are buffered with their PCs in
//   a small prefetch FIFO, which is presented downstream via valid/ready.
//   Branch/JR redirects flush the FIFO. A redirect to address 0 halts fetch
//   until reset.
//
// Ports:
//   clk              in   1   clock, all state updates on the rising edge
//   reset            in   1   synchronous, active-high reset
//   imem_addr        out  32  instruction memory byte address (word aligned)
//   imem_read        out  1   read request, address held stable until accepted
//   imem_waitrequest in   1   memory stall; read accepted when read & !wait
//   imem_readdata    in   32  read data, valid in the acceptance cycle
//   redirect         in   1   taken branch/jump/JR this cycle
//   redirect_addr    in   32  redirect target, bits [1:0] ignored
//   instr_valid      out  1   FIFO head holds a valid instruction
//   instr_word       out  32  FIFO head instruction (0 when empty)
//   instr_pc         out  32  PC of instr_word (0 when empty)
//   instr_ready      in   1   consumer takes the head when valid & ready
//   halted           out  1   fetch stopped after a redirect to 32'h0
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter int          FIFO_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_read,
  input  logic        imem_waitrequest,
  input  logic [31:0] imem_readdata,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        instr_valid,
  output logic [31:0] instr_word,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        halted
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    RUN,
    FLUSH_WAIT,
    HALTED
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [31:0]       fetch_pc;
  logic [31:0]       fetch_pc_next;
  logic [31:0]       target;
  logic [31:0]       target_next;
  logic [31:0]       redirect_target;
  logic [31:0]       wait_target;

  logic [31:0]       fifo_pc   [FIFO_DEPTH];
  logic [31:0]       fifo_word [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic              accept;
  logic              push;
  logic              pop;
  logic              flush;

  // The low two target bits are dropped on purpose; this sink keeps them
  // visibly consumed rather than silently dangling.
  logic              unused_addr_bits;
  assign unused_addr_bits = ^redirect_addr[1:0];

  // Handshake and FIFO-facing outputs. The address never moves while a read
  // is outstanding: in FLUSH_WAIT fetch_pc still holds the stalled address
  // because the new target is parked in 'target' instead.
  always_comb begin
    redirect_target = {redirect_addr[31:2], 2'b00};
    imem_read       = 1'b0;
    case (state)
      RUN:        imem_read = (count < DEPTH_CNT);
      FLUSH_WAIT: imem_read = 1'b1;
      default:    imem_read = 1'b0;
    endcase
    if (reset) begin
      imem_read = 1'b0;
    end
    imem_addr   = fetch_pc;
    accept      = imem_read & ~imem_waitrequest;
    instr_valid = (count != '0);
    pop         = instr_valid & instr_ready;
    instr_word  = instr_valid ? fifo_word[rd_ptr] : 32'h0;
    instr_pc    = instr_valid ? fifo_pc[rd_ptr]   : 32'h0;
    halted      = (state == HALTED);
  end

  // Next-state logic. A redirect outranks push/pop. If the memory is
  // stalling we cannot drop the request, so the target is parked and the
  // stale data discarded once the read finally completes. A redirect that
  // arrives in FLUSH_WAIT replaces the parked target, including in the very
  // cycle the stalled read completes.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    target_next   = target;
    push          = 1'b0;
    flush         = 1'b0;
    wait_target   = redirect ? redirect_target : target;
    case (state)
      RUN: begin
        if (redirect) begin
          flush = 1'b1;
          if (imem_read && imem_waitrequest) begin
            target_next = redirect_target;
            state_next  = FLUSH_WAIT;
          end else begin
            fetch_pc_next = redirect_target;
            if (redirect_target == 32'h0) begin
              state_next = HALTED;
            end
          end
        end else if (accept) begin
          push          = 1'b1;
          fetch_pc_next = fetch_pc + 32'd4;
        end
      end
      FLUSH_WAIT: begin
        if (redirect) begin
          target_next = redirect_target;
          flush       = 1'b1;
        end
        if (accept) begin
          fetch_pc_next = wait_target;
          state_next    = (wait_target == 32'h0) ? HALTED : RUN;
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // State, PC and parked-target registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      fetch_pc <= RESET_VECTOR;
      target   <= 32'h0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      target   <= target_next;
    end
  end

  // FIFO bookkeeping. Pointers wrap naturally since the depth is a power of
  // two. A flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage has no reset; entries are only observable once counted.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= fetch_pc;
      fifo_word[wr_ptr] <= imem_readdata;
    end
  end

endmodule
